spike_pair_scheduler: RTL and testbench



---
 rtl/spike_pair_scheduler.sv | 142 ++++++++++++++
 tb/tb_spike_pair_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_pair_scheduler.sv
// Double-buffered spike vector source: presents one timestep's spikes two neurons
// at a time to the population controller, advancing on shift_en during SYN_ACCU.
module spike_pair_scheduler #(
  parameter int N_NUM     = 32,
  parameter int N_SZ      = 5,
  parameter int SKIP_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic [N_NUM-1:0] spike_in,
  input  logic             spike_in_valid,
  output logic             spike_in_ready,
  input  logic             shift_en,
  output logic [N_SZ-1:0]  rf_addr,
  output logic [1:0]       spike,
  output logic             accu_done
);

  localparam int NP = N_NUM / 2;
  localparam int PTR_W = N_SZ - 1;
  localparam logic [2:0] SYN_ACCU = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t             fsm;
  logic [N_NUM-1:0] shadow;
  logic [N_NUM-1:0] active;
  logic             shadow_full;
  logic [2:0]       prev_state;
  logic [PTR_W-1:0] pair_ptr;
  logic             accu_done_r;

  logic             entry;
  logic [N_NUM-1:0] entry_vec;
  logic [NP-1:0]    entry_nz;
  logic [NP-1:0]    active_nz;
  logic             first_found;
  logic [PTR_W-1:0] first_idx;
  logic             next_found;
  logic [PTR_W-1:0] next_idx;

  assign entry     = (state == SYN_ACCU) && (prev_state != SYN_ACCU);
  assign entry_vec = shadow_full ? shadow : '0;

  always_comb begin
    entry_nz  = '0;
    active_nz = '0;
    for (int i = 0; i < NP; i++) begin
      entry_nz[i]  = |entry_vec[2*i +: 2];
      active_nz[i] = |active[2*i +: 2];
    end
  end

  // Descending scans so the lowest qualifying pair is the last one written.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    if (SKIP_ZERO != 0) begin
      for (int i = NP - 1; i >= 0; i--) begin
        if (entry_nz[i]) begin
          first_found = 1'b1;
          first_idx   = PTR_W'(i);
        end
        if (active_nz[i] && (i > int'(pair_ptr))) begin
          next_found = 1'b1;
          next_idx   = PTR_W'(i);
        end
      end
    end else begin
      first_found = 1'b1;
      first_idx   = '0;
      next_found  = (pair_ptr != PTR_W'(NP - 1));
      next_idx    = pair_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm         <= S_IDLE;
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
      prev_state  <= 3'd0;
      pair_ptr    <= '0;
      accu_done_r <= 1'b0;
    end else begin
      prev_state  <= state;
      accu_done_r <= 1'b0;

      // A load and an entry transfer never coincide: the load needs an empty shadow.
      if (spike_in_valid && !shadow_full) begin
        shadow      <= spike_in;
        shadow_full <= 1'b1;
      end else if (entry && shadow_full) begin
        shadow_full <= 1'b0;
      end

      case (fsm)
        S_IDLE: begin
          if (entry) begin
            active <= entry_vec;
            if (first_found) begin
              pair_ptr <= first_idx;
              fsm      <= S_RUN;
            end else begin
              pair_ptr    <= '0;
              fsm         <= S_DONE;
              accu_done_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (state != SYN_ACCU) begin
            fsm      <= S_IDLE;
            pair_ptr <= '0;
            active   <= '0;
          end else if (shift_en) begin
            if (next_found) begin
              pair_ptr <= next_idx;
            end else begin
              fsm         <= S_DONE;
              accu_done_r <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (state != SYN_ACCU) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign spike_in_ready = !shadow_full;
  assign rf_addr        = (fsm == S_RUN) ? {pair_ptr, 1'b0} : '0;
  assign spike          = (fsm == S_RUN) ? active[{pair_ptr, 1'b0} +: 2] : 2'b00;
  assign accu_done      = accu_done_r;

endmodule

// File: tb/tb_spike_pair_scheduler.sv
// Bench for spike_pair_scheduler: one instance per SKIP_ZERO setting, both driven
// identically and checked every cycle against a visit-list model of the timestep.
module tb_spike_pair_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [31:0] spike_in;
  logic        spike_in_valid;
  logic        shift_en;

  logic       rdy_o  [2];
  logic [4:0] rf_o   [2];
  logic [1:0] sp_o   [2];
  logic       done_o [2];

  int n_cmp = 0;
  int n_err = 0;

  // Model: the list of pairs a timestep visits, and the position reached in it.
  logic [31:0] m_shadow;
  bit          m_full;
  logic [2:0]  m_prev;
  logic [31:0] m_act  [2];
  int          m_list [2][16];
  int          m_len  [2];
  int          m_pos  [2];
  bit          m_run  [2];
  bit          m_pulse[2];

  spike_pair_scheduler #(.N_NUM(32), .N_SZ(5), .SKIP_ZERO(0)) dut_full (
    .clk(clk), .rst(rst), .state(state), .spike_in(spike_in),
    .spike_in_valid(spike_in_valid), .spike_in_ready(rdy_o[0]), .shift_en(shift_en),
    .rf_addr(rf_o[0]), .spike(sp_o[0]), .accu_done(done_o[0])
  );

  spike_pair_scheduler #(.N_NUM(32), .N_SZ(5), .SKIP_ZERO(1)) dut_skip (
    .clk(clk), .rst(rst), .state(state), .spike_in(spike_in),
    .spike_in_valid(spike_in_valid), .spike_in_ready(rdy_o[1]), .shift_en(shift_en),
    .rf_addr(rf_o[1]), .spike(sp_o[1]), .accu_done(done_o[1])
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit          entry;
    bit          old_full;
    logic [31:0] vec;
    if (!rst) begin
      m_shadow = '0;
      m_full   = 1'b0;
      m_prev   = 3'd0;
      for (int m = 0; m < 2; m++) begin
        m_act[m] = '0; m_len[m] = 0; m_pos[m] = 0; m_run[m] = 1'b0; m_pulse[m] = 1'b0;
      end
    end else begin
      entry    = (state == 3'd2) && (m_prev != 3'd2);
      old_full = m_full;
      vec      = old_full ? m_shadow : 32'h0;
      for (int m = 0; m < 2; m++) begin
        m_pulse[m] = 1'b0;
        if (entry) begin
          m_len[m] = 0;
          for (int p = 0; p < 16; p++)
            if (m == 0 || vec[2*p +: 2] != 2'b00) begin
              m_list[m][m_len[m]] = p;
              m_len[m]++;
            end
          m_act[m] = vec;
          m_pos[m] = 0;
          m_run[m] = (m_len[m] != 0);
          m_pulse[m] = (m_len[m] == 0);
        end else if (m_run[m]) begin
          if (state != 3'd2) begin
            m_run[m] = 1'b0;
          end else if (shift_en) begin
            m_pos[m]++;
            if (m_pos[m] == m_len[m]) begin
              m_run[m]   = 1'b0;
              m_pulse[m] = 1'b1;
            end
          end
        end
      end
      if (entry && old_full) m_full = 1'b0;
      if (spike_in_valid && !old_full) begin
        m_shadow = spike_in;
        m_full   = 1'b1;
      end
      m_prev = state;
    end
  endtask

  task automatic checkOutput();
    int p;
    logic [31:0] exp_rf, exp_sp;
    for (int m = 0; m < 2; m++) begin
      exp_rf = 0;
      exp_sp = 0;
      if (m_run[m]) begin
        p      = m_list[m][m_pos[m]];
        exp_rf = 32'(2 * p);
        exp_sp = 32'(m_act[m][2*p +: 2]);
      end
      cmp($sformatf("rf_addr[skip=%0d]", m), 32'(rf_o[m]), exp_rf);
      cmp($sformatf("spike[skip=%0d]", m), 32'(sp_o[m]), exp_sp);
      cmp($sformatf("accu_done[skip=%0d]", m), 32'(done_o[m]), 32'(m_pulse[m]));
      cmp($sformatf("ready[skip=%0d]", m), 32'(rdy_o[m]), 32'(!m_full));
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks half a cycle later.
  task automatic applyStimulus(input logic [2:0] st, input logic vld,
                               input logic [31:0] din, input logic sh);
    state          = st;
    spike_in_valid = vld;
    spike_in       = din;
    shift_en       = sh;
    @(posedge clk);
    model_update();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(3'd0, 1'b0, 32'h0, 1'b0);
    applyStimulus(3'd0, 1'b0, 32'h0, 1'b0);
    cmp("reset_ready", 32'(rdy_o[0]), 32'd1);
    cmp("reset_spike", 32'(sp_o[0]), 32'd0);
    cmp("reset_rf_addr", 32'(rf_o[0]), 32'd0);
    cmp("reset_accu_done", 32'(done_o[1]), 32'd0);
    rst = 1'b1;

    // Full sweep of 0x5 without skipping; skipping instance sees pairs 0 and 1 only.
    applyStimulus(3'd1, 1'b1, 32'h0000_0005, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
      if (i < 16) cmp("sweep_rf_addr", 32'(rf_o[0]), 32'(2 * i));
      else        cmp("sweep_accu_done", 32'(done_o[0]), 32'd1);
      if (i == 2) cmp("skip5_accu_done", 32'(done_o[1]), 32'd1);
    end
    applyStimulus(3'd3, 1'b1, 32'h8000_0003, 1'b0);
    applyStimulus(3'd3, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
      if (i == 0) cmp("skip_first_spike", 32'(sp_o[1]), 32'd3);
      if (i == 1) cmp("skip_last_rf_addr", 32'(rf_o[1]), 32'd30);
      if (i == 1) cmp("skip_last_spike", 32'(sp_o[1]), 32'd2);
      if (i == 2) cmp("skip_accu_done", 32'(done_o[1]), 32'd1);
    end
    applyStimulus(3'd3, 1'b1, 32'h5555_5555, 1'b0);

    // Stall at rf_addr 4, with a shadow load and an ignored second load mid-run.
    applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    applyStimulus(3'd2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    cmp("shadow_loaded_ready", 32'(rdy_o[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd2, 1'b1, 32'h1234_5678, 1'b0);
      cmp("hold_rf_addr", 32'(rf_o[0]), 32'd4);
      cmp("hold_spike", 32'(sp_o[1]), 32'd1);
    end
    applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    cmp("resume_rf_addr", 32'(rf_o[0]), 32'd6);
    for (int i = 0; i < 14; i++) applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    applyStimulus(3'd3, 1'b0, 32'h0, 1'b0);

    // Next entry consumes 0xFFFF_FFFF; abort at rf_addr 10.
    applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    cmp("transfer_ready", 32'(rdy_o[0]), 32'd1);
    cmp("transfer_spike", 32'(sp_o[0]), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    cmp("pre_abort_rf_addr", 32'(rf_o[1]), 32'd10);
    applyStimulus(3'd3, 1'b0, 32'h0, 1'b0);
    cmp("abort_rf_addr", 32'(rf_o[0]), 32'd0);
    cmp("abort_spike", 32'(sp_o[1]), 32'd0);
    cmp("abort_accu_done", 32'(done_o[0]), 32'd0);

    // Entry with an empty shadow.
    applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    cmp("empty_entry_accu_done", 32'(done_o[1]), 32'd1);
    for (int i = 0; i < 17; i++) applyStimulus(3'd2, 1'b0, 32'h0, 1'b1);
    applyStimulus(3'd4, 1'b0, 32'h0, 1'b0);

    // Randomized phase traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(99) != 0);
      applyStimulus(($urandom_range(9) < 7) ? 3'd2 : 3'($urandom_range(6)),
                    1'($urandom_range(9) < 3),
                    ($urandom_range(1) == 0) ? $urandom : ($urandom & $urandom & $urandom),
                    1'($urandom_range(9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
